// File: rtl/ifq_pkg.sv
// Shared constants and helpers for the instruction prefetch queue.
// Optional build macro used by the queue: IFQ_BYPASS_EN.
package ifq_pkg;

  localparam int IFQ_IWIDTH = 24;
  localparam int IFQ_AWIDTH = 24;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ifq_store.sv
// Queue storage: DEPTH entries of {pc, instr}, one write port, asynchronous head read.
module ifq_store #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTRW-1:0]  i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTRW-1:0]  i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // No reset on the array: occupancy is tracked by the control logic.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between 1-cycle-latency instruction memory and decode.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int IWIDTH   = IFQ_IWIDTH,
  parameter int AWIDTH   = IFQ_AWIDTH,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic              i_clk_en,
  output logic [AWIDTH-1:0] o_iaddr,
  output logic              o_ireq,
  input  logic [IWIDTH-1:0] i_instr,
  input  logic              i_flush,
  input  logic [AWIDTH-1:0] i_flush_addr,
  output logic              o_valid,
  output logic [IWIDTH-1:0] o_instr,
  output logic [AWIDTH-1:0] o_pc,
  input  logic              i_ready
);

  localparam int PTRW = clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW:0] DEPTH_V = (CNTW + 1)'(DEPTH);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] req_pc_q, req_pc_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic              inflight_q, inflight_d;

  logic [IWIDTH-1:0] st_instr;
  logic [AWIDTH-1:0] st_pc;
  logic              resp, empty, bypass, pop, pop_store, push, issue;
  logic [CNTW:0]     occ;

  ifq_store #(
    .WIDTH (AWIDTH + IWIDTH),
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_store (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_ptr_q),
    .i_wdata ({req_pc_q, i_instr}),
    .i_raddr (rd_ptr_q),
    .o_rdata ({st_pc, st_instr})
  );

  always_comb begin
    resp  = inflight_q & ~i_flush;
    empty = (count_q == '0);
`ifdef IFQ_BYPASS_EN
    bypass = resp & empty;
`else
    bypass = 1'b0;
`endif
    o_valid = i_rstb & (~empty | bypass);
    o_instr = bypass ? i_instr : st_instr;
    o_pc    = bypass ? req_pc_q : st_pc;
    o_iaddr = pc_q;

    pop       = o_valid & i_ready & i_clk_en & ~i_flush;
    pop_store = pop & ~empty;
    // A bypassed response taken by decode this cycle never touches storage.
    push      = resp & i_clk_en & ~(bypass & pop);

    occ    = (CNTW + 1)'(count_q) + (CNTW + 1)'(inflight_q) - (CNTW + 1)'(pop);
    o_ireq = i_rstb & ~i_flush & (occ < DEPTH_V);
    issue  = o_ireq & i_clk_en;

    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = inflight_q;

    if (i_clk_en) begin
      if (i_flush) begin
        pc_d       = i_flush_addr;
        count_d    = '0;
        rd_ptr_d   = '0;
        wr_ptr_d   = '0;
        inflight_d = 1'b0;
      end else begin
        if (issue) begin
          pc_d     = pc_q + AWIDTH'(1);
          req_pc_d = pc_q;
        end
        inflight_d = issue;
        if (push)      wr_ptr_d = wr_ptr_q + PTRW'(1);
        if (pop_store) rd_ptr_d = rd_ptr_q + PTRW'(1);
        count_d = count_q + CNTW'(push) - CNTW'(pop_store);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      pc_q       <= AWIDTH'(RESET_PC);
      req_pc_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised instruction prefetch queue between instruction memory and the CPU decode stage (cpu_2432 successor cores).
- Decouples fetch from decode, giving decode backpressure (stall) capability that the current fixed-pipeline core lacks.
- Generalised in instruction width, address width and queue depth.
- Redirects fetch on taken jump/branch, flushing stale entries and any in-flight response.

Parameters:
- IWIDTH, 24, instruction width in bits.
- AWIDTH, 24, instruction address width in bits (word addresses).
- DEPTH, 4, queue entries; power of 2, minimum 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- i_clk  in  1  clock.
- i_rstb  in  1  reset; synchronous, active-low.
- i_clk_en  in  1  global clock enable; when low, all state holds.
- o_iaddr  out  AWIDTH  fetch address to instruction memory.
- o_ireq  out  1  fetch request; issued when o_ireq & i_clk_en.
- i_instr  in  IWIDTH  memory read data, valid exactly one enabled cycle after issue.
- i_flush  in  1  redirect request (taken jump).
- i_flush_addr  in  AWIDTH  redirect target.
- o_valid  out  1  head entry valid to decode.
- o_instr  out  IWIDTH  head instruction.
- o_pc  out  AWIDTH  address of head instruction.
- i_ready  in  1  decode accepts head; pop = o_valid & i_ready & i_clk_en & !i_flush.

Behaviour:
- All state updates only on posedge i_clk with i_clk_en=1. Reset is applied on posedge with i_rstb=0 regardless of i_clk_en.
- Reset values:
  - fetch PC = RESET_PC; count = 0; rd_ptr = 0; wr_ptr = 0; inflight = 0.
  - o_valid = 0; o_ireq = 0 during reset. o_instr and o_pc are don't-care while o_valid = 0.
  - o_ireq rises in the first cycle after reset release.
- Fixed memory latency of 1:
  - A request issued in cycle N sets inflight.
  - i_instr and its address (held in a registered copy of the fetch PC) are written to the tail at the end of cycle N+1.
  - The entry is visible on o_valid in N+2.
- Issue rule: o_ireq = !i_flush & (count + inflight − pop) < DEPTH. This sustains one instruction per cycle when DEPTH >= 2.
- On issue, fetch PC increments by 1, wrapping modulo 2^AWIDTH.
- Full condition: count == DEPTH implies o_ireq = 0. An overflow write is impossible by construction; the bench asserts this.
- Empty condition: count == 0 implies o_valid = 0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer widths are log2(DEPTH); pointers wrap naturally.
- Flush (i_flush=1 with i_clk_en=1):
  - Next state: count = 0, pointers = 0, fetch PC = i_flush_addr, inflight = 0.
  - Any response arriving in the flush cycle is discarded.
  - The cycle after the flush: o_valid = 0, o_ireq = 1, o_iaddr = i_flush_addr.
  - Flush beats pop and push in the same cycle.
  - A flush in the same cycle as reset: reset wins.
- i_clk_en low mid-operation: no issue, no push, no pop. Memory is stalled with the same enable, so an in-flight response stays pending.
- Reset mid-operation: all contents and in-flight data are discarded.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when count == 0 and a response arrives (inflight & !i_flush), i_instr and its PC drive o_instr/o_pc combinationally with o_valid = 1.
  - If i_ready, the entry is consumed without a write.
  - Otherwise it is written as usual.
  - Request-to-decode latency becomes 1 cycle.
- Undefined: o_valid, o_instr and o_pc come only from queue storage; latency is 2 cycles.

Decomposition:
- Package ifq_pkg: clog2 function for pointer width; default IWIDTH/AWIDTH constants shared with cpu_2432.vh.
- One sub-module, ifq_store: DEPTH x (IWIDTH+AWIDTH) register array with write port and asynchronous read of the head.
- Control (pointers, count, inflight, fetch PC) stays in the top module.

Test Plan:
- Reset release with i_ready=1 and memory returning instr = 0x100000 + addr:
  - Bypass off: o_valid first at cycle 2 with o_pc=0, o_instr=0x100000.
  - Then one instruction per cycle, o_pc = 1, 2, 3, …
- Fill to full with i_ready=0, DEPTH=4:
  - count reaches 4; o_ireq low from the cycle count+inflight hits 4.
  - Raising i_ready drains o_pc 0..3 in order with no gaps or duplicates.
- Flush:
  - i_flush=1 with i_flush_addr=0x000040 while queue holds 3 entries and 1 is in flight.
  - Next cycle: o_valid=0, o_iaddr=0x40.
  - Next instruction delivered has o_pc=0x40; no stale PC ever appears.
- i_clk_en toggled 1,0,0,1 during streaming: o_pc sequence continuous, no loss or duplication.
- Wrap: AWIDTH=8, RESET_PC=0xFE, i_ready=1: delivered o_pc sequence is FE, FF, 00, 01.
- IFQ_BYPASS_EN defined, empty queue, i_ready=1: o_valid at cycle 1 after first issue with o_pc=RESET_PC; sustained rate one instruction per cycle.
